// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU fetch (I) and data (D) accesses onto a single-port RAM.
// Rev 1.0 -- initial release.
`default_nettype none

module mem_bus_arbiter #(
  parameter int WAIT_CYCLES     = 0,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [3:0]  ram_mode,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_SW  = 4'd6;
  localparam logic [3:0] IO_SH  = 4'd7;
  localparam logic [3:0] IO_SB  = 4'd8;

  localparam int CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 owner_d;
  logic [3:0]           lat_mode;
  logic [CNT_W-1:0]     cnt;
  logic [STREAK_W-1:0]  streak;
  logic                 grant_d;
  logic                 grant_i;
  logic                 is_store;
  logic                 last_cycle;

  // D wins ties until it has starved a waiting fetch MAX_DATA_STREAK times in a row.
  assign grant_d    = d_req && (!i_req || (streak != STREAK_W'(MAX_DATA_STREAK)));
  assign grant_i    = i_req && !grant_d;
  assign is_store   = (lat_mode == IO_SW) || (lat_mode == IO_SH) || (lat_mode == IO_SB);
  assign last_cycle = (cnt == '0);
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    ram_mode   = IO_NOP;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d || grant_i) state_next = ACCESS;
      end
      ACCESS: begin
        // Stores are held off the bus until the last wait cycle so the RAM writes only once.
        ram_mode = (is_store && !last_cycle) ? IO_NOP : lat_mode;
        if (last_cycle) state_next = RESP;
      end
      RESP: begin
        i_ack      = !owner_d;
        d_ack      = owner_d;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      lat_mode  <= IO_NOP;
      ram_addr  <= '0;
      ram_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      cnt       <= '0;
      streak    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d   <= 1'b1;
            lat_mode  <= d_mode;
            ram_addr  <= d_addr;
            ram_wdata <= d_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            if (i_req) streak <= streak + 1'b1;
          end else if (grant_i) begin
            owner_d   <= 1'b0;
            lat_mode  <= IO_LW;
            ram_addr  <= i_addr;
            ram_wdata <= '0;
            cnt       <= CNT_W'(WAIT_CYCLES);
            streak    <= '0;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!owner_d)      i_rdata <= ram_rdata;
            else if (!is_store) d_rdata <= ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of the arbiter at WAIT_CYCLES 0, 2 and 3 against a mock RAM.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_mem_bus_arbiter;

  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LH  = 4'd2;
  localparam logic [3:0] IO_LHU = 4'd3;
  localparam logic [3:0] IO_LB  = 4'd4;
  localparam logic [3:0] IO_LBU = 4'd5;
  localparam logic [3:0] IO_SW  = 4'd6;
  localparam logic [3:0] IO_SH  = 4'd7;
  localparam logic [3:0] IO_SB  = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_mode;

  logic        i_ack0, d_ack0, busy0, i_ack2, d_ack2, busy2, i_ack3, d_ack3, busy3;
  logic [31:0] i_rdata0, d_rdata0, ram_addr0, ram_wdata0, ram_rdata0;
  logic [31:0] i_rdata2, d_rdata2, ram_addr2, ram_wdata2, ram_rdata2;
  logic [31:0] i_rdata3, d_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
  logic [3:0]  ram_mode0, ram_mode2, ram_mode3;

  logic [31:0] mem0 [16];
  logic [31:0] mem2 [16];
  logic [31:0] mem3 [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_CYCLES(0), .MAX_DATA_STREAK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack0),
    .d_rdata(d_rdata0), .ram_mode(ram_mode0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .ram_rdata(ram_rdata0), .busy(busy0));

  mem_bus_arbiter #(.WAIT_CYCLES(2), .MAX_DATA_STREAK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack2), .i_rdata(i_rdata2),
    .d_req(d_req), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack2),
    .d_rdata(d_rdata2), .ram_mode(ram_mode2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
    .ram_rdata(ram_rdata2), .busy(busy2));

  mem_bus_arbiter #(.WAIT_CYCLES(3), .MAX_DATA_STREAK(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack3),
    .d_rdata(d_rdata3), .ram_mode(ram_mode3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .busy(busy3));

  // Mock RAM: little-endian byte lanes, combinational extended read, synchronous write.
  function automatic logic [31:0] rd(input logic [31:0] word, input logic [3:0] mode,
                                     input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (mode)
      IO_LH:   rd = {{16{h[15]}}, h};
      IO_LHU:  rd = {16'h0000, h};
      IO_LB:   rd = {{24{b[7]}}, b};
      IO_LBU:  rd = {24'h000000, b};
      default: rd = word;
    endcase
  endfunction

  function automatic logic [31:0] wr(input logic [31:0] old, input logic [3:0] mode,
                                     input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    case (mode)
      IO_SW:   mask = 32'hFFFF_FFFF;
      IO_SH:   mask = 32'h0000_FFFF << {off[1], 4'b0000};
      IO_SB:   mask = 32'h0000_00FF << {off, 3'b000};
      default: mask = 32'h0000_0000;
    endcase
    wr = (old & ~mask) | ((wd << ((mode == IO_SW) ? 5'd0 :
          (mode == IO_SH) ? {off[1], 4'b0000} : {off, 3'b000})) & mask);
  endfunction

  assign ram_rdata0 = rd(mem0[ram_addr0[5:2]], ram_mode0, ram_addr0[1:0]);
  assign ram_rdata2 = rd(mem2[ram_addr2[5:2]], ram_mode2, ram_addr2[1:0]);
  assign ram_rdata3 = rd(mem3[ram_addr3[5:2]], ram_mode3, ram_addr3[1:0]);

  always @(posedge clk) begin
    if (pre_we) begin
      mem0[pre_idx] <= pre_data;
      mem2[pre_idx] <= pre_data;
      mem3[pre_idx] <= pre_data;
    end else begin
      mem0[ram_addr0[5:2]] <= wr(mem0[ram_addr0[5:2]], ram_mode0, ram_addr0[1:0], ram_wdata0);
      mem2[ram_addr2[5:2]] <= wr(mem2[ram_addr2[5:2]], ram_mode2, ram_addr2[1:0], ram_wdata2);
      mem3[ram_addr3[5:2]] <= wr(mem3[ram_addr3[5:2]], ram_mode3, ram_addr3[1:0], ram_wdata3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    cyc(1);
    pre_we = 1'b0;
  endtask

  // Leaves the bench at a negedge with all DUTs idle; the current cycle is "cycle 0".
  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_mode = IO_NOP;
    cyc(2);
    preload(4'd0,  32'h1234_5678);
    preload(4'd1,  32'hA5A5_0001);
    preload(4'd2,  32'h0BAD_F00D);
    preload(4'd8,  32'h0000_0000);
    preload(4'd12, 32'h1111_1111);

    // Reset state
    chk("rst_busy",    32'(busy0), 32'd0);
    chk("rst_mode",    32'(ram_mode0), 32'(IO_NOP));
    chk("rst_addr",    ram_addr0, 32'd0);
    chk("rst_wdata",   ram_wdata0, 32'd0);
    chk("rst_acks",    32'({i_ack0, d_ack0}), 32'd0);
    chk("rst_i_rdata", i_rdata0, 32'd0);
    chk("rst_d_rdata", d_rdata0, 32'd0);

    // Fetch, W=0
    do_reset();
    i_req = 1'b1; i_addr = 32'h100;
    cyc(1);
    chk("t1_mode_c1", 32'(ram_mode0), 32'(IO_LW));
    chk("t1_addr_c1", ram_addr0, 32'h100);
    chk("t1_iack_c1", 32'(i_ack0), 32'd0);
    cyc(1);
    chk("t1_iack_c2", 32'(i_ack0), 32'd1);
    chk("t1_rdata",   i_rdata0, 32'h1234_5678);
    chk("t1_dack_c2", 32'(d_ack0), 32'd0);
    i_req = 1'b0;
    cyc(1);
    chk("t1_iack_c3", 32'(i_ack0), 32'd0);
    chk("t1_busy_c3", 32'(busy0), 32'd0);

    // Store with two wait states, then read back
    do_reset();
    d_req = 1'b1; d_mode = IO_SW; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    cyc(1);
    chk("t2_mode_c1", 32'(ram_mode2), 32'(IO_NOP));
    chk("t2_busy_c1", 32'(busy2), 32'd1);
    cyc(1);
    chk("t2_mode_c2", 32'(ram_mode2), 32'(IO_NOP));
    cyc(1);
    chk("t2_mode_c3",  32'(ram_mode2), 32'(IO_SW));
    chk("t2_wdata_c3", ram_wdata2, 32'hDEAD_BEEF);
    chk("t2_dack_c3",  32'(d_ack2), 32'd0);
    cyc(1);
    chk("t2_dack_c4",  32'(d_ack2), 32'd1);
    chk("t2_mode_c4",  32'(ram_mode2), 32'(IO_NOP));
    chk("t2_mem",      mem2[8], 32'hDEAD_BEEF);
    d_mode = IO_LW;
    cyc(4);
    chk("t2_ld_dack_c8", 32'(d_ack2), 32'd0);
    cyc(1);
    chk("t2_ld_dack_c9", 32'(d_ack2), 32'd1);
    chk("t2_ld_rdata",   d_rdata2, 32'hDEAD_BEEF);
    d_req = 1'b0;

    // Simultaneous requests: D first, I acked three cycles after D
    do_reset();
    d_req = 1'b1; d_mode = IO_LW; d_addr = 32'h4;
    i_req = 1'b1; i_addr = 32'h8;
    cyc(1);
    chk("t3_addr_c1", ram_addr0, 32'h4);
    cyc(1);
    chk("t3_acks_c2", 32'({i_ack0, d_ack0}), 32'b01);
    chk("t3_drdata",  d_rdata0, 32'hA5A5_0001);
    d_req = 1'b0;
    cyc(1);
    chk("t3_acks_c3", 32'({i_ack0, d_ack0}), 32'b00);
    cyc(1);
    chk("t3_addr_c4", ram_addr0, 32'h8);
    cyc(1);
    chk("t3_acks_c5", 32'({i_ack0, d_ack0}), 32'b10);
    chk("t3_irdata",  i_rdata0, 32'h0BAD_F00D);
    i_req = 1'b0;

    // Streak limit: D,D,D,D,I,D
    do_reset();
    d_req = 1'b1; d_mode = IO_LW; d_addr = 32'h4;
    i_req = 1'b1; i_addr = 32'h8;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk($sformatf("t4_grant%0d", k), ram_addr0, (k == 4) ? 32'h8 : 32'h4);
      cyc(1);
      chk($sformatf("t4_acks%0d", k), 32'({i_ack0, d_ack0}), (k == 4) ? 32'b10 : 32'b01);
      cyc(1);
    end
    d_req = 1'b0; i_req = 1'b0;

    // Byte loads with sign/zero extension, then a NOP-mode access
    rst_n = 1'b0;
    preload(4'd0, 32'h8011_2233);
    do_reset();
    d_req = 1'b1; d_mode = IO_LB; d_addr = 32'h3;
    cyc(2);
    chk("t5_lb_ack",   32'(d_ack0), 32'd1);
    chk("t5_lb_rdata", d_rdata0, 32'hFFFF_FF80);
    d_mode = IO_LBU;
    cyc(3);
    chk("t5_lbu_ack",   32'(d_ack0), 32'd1);
    chk("t5_lbu_rdata", d_rdata0, 32'h0000_0080);
    d_mode = IO_NOP; d_addr = 32'h0;
    cyc(2);
    chk("t5_nop_mode", 32'(ram_mode0), 32'(IO_NOP));
    cyc(1);
    chk("t5_nop_ack",   32'(d_ack0), 32'd1);
    chk("t5_nop_rdata", d_rdata0, 32'h8011_2233);
    d_req = 1'b0;

    // Reset during the first cycle of a W=3 store
    do_reset();
    d_req = 1'b1; d_mode = IO_SW; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D;
    cyc(1);
    chk("t6_busy_c1", 32'(busy3), 32'd1);
    rst_n = 1'b0; d_req = 1'b0;
    cyc(1);
    chk("t6_busy_rst", 32'(busy3), 32'd0);
    chk("t6_mode_rst", 32'(ram_mode3), 32'(IO_NOP));
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      seen = seen | d_ack3 | i_ack3;
    end
    chk("t6_no_ack", 32'(seen), 32'd0);
    chk("t6_mem",    mem3[12], 32'h1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
